fc_inneuron_loader: RTL

Write-side counterpart of the FC-layer controller. Accepts a valid/ready stream of input-neuron words, packs them in pairs into the PI banks of dual-port M9K input-neuron RAM (port a even word, port b odd word, same cycle), then raises the FC enable. Sits between the previous layer's output stream and the FC input-neuron RAM. The FC controller then reads the RAM back in bank order using the same address layout.

---
 rtl/fc_inneuron_loader.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/fc_inneuron_loader.sv
// -----------------------------------------------------------------------------
// fc_inneuron_loader
//
// Purpose:
//   Write-side loader for the FC-layer input-neuron RAM. Accepts a valid/ready
//   stream of neuron words and packs consecutive words in pairs into PI banks
//   of dual-port RAM. The even word goes to port a and the odd word to port b,
//   both in the same cycle. When the whole frame is written it pulses done
//   and raises fc_enable for the FC controller.
//
//   Bank k holds words k*INNEURON/PI .. (k+1)*INNEURON/PI-1 at local addresses
//   0 .. INNEURON/PI-1. This is the same layout the FC controller reads back.
//
// Ports:
//   clock             single clock, rising edge
//   reset             asynchronous, active-low reset
//   start             begin a new load frame (sampled only in IDLE)
//   in_data/in_valid  input neuron stream
//   in_ready          loader accepts a word this cycle (decoded from state only)
//   in_neuron_addr_a  port-a write address, shared by all banks
//   in_neuron_addr_b  port-b write address, shared by all banks
//   in_neuron_data_a  port-a write data, broadcast to all banks
//   in_neuron_data_b  port-b write data, broadcast to all banks
//   in_neuron_wren_a  per-bank port-a write enable
//   in_neuron_wren_b  per-bank port-b write enable
//   busy              frame in progress
//   done              one-cycle pulse when the frame is fully written
//   fc_enable         level enable to the FC controller
// -----------------------------------------------------------------------------
module fc_inneuron_loader #(
  parameter int INNEURON               = 192,
  parameter int PI                     = 3,
  parameter int DATA_WIDTH_FC          = 16,
  parameter int FC_INNEURON_ADDR_WIDTH = 6
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              start,
  input  logic [DATA_WIDTH_FC-1:0]          in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_addr_a,
  output logic [FC_INNEURON_ADDR_WIDTH-1:0] in_neuron_addr_b,
  output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_a,
  output logic [DATA_WIDTH_FC-1:0]          in_neuron_data_b,
  output logic [PI-1:0]                     in_neuron_wren_a,
  output logic [PI-1:0]                     in_neuron_wren_b,
  output logic                              busy,
  output logic                              done,
  output logic                              fc_enable
);

  // Pairs stored per bank; the local pair counter is one bit narrower than
  // the RAM address because the LSB of the address selects even/odd port.
  localparam int PAIRS_PER_BANK = INNEURON / 2 / PI;
  localparam int LOCAL_W        = FC_INNEURON_ADDR_WIDTH - 1;
  localparam int BANK_W         = (PI > 1) ? $clog2(PI) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVEN = 2'd1,
    ODD  = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t                              state_reg;
  logic [LOCAL_W-1:0]                  local_reg;
  logic [BANK_W-1:0]                   bank_reg;
  logic [DATA_WIDTH_FC-1:0]            hold_reg;
  logic [FC_INNEURON_ADDR_WIDTH-1:0]   addr_a_reg;
  logic [FC_INNEURON_ADDR_WIDTH-1:0]   addr_b_reg;
  logic [DATA_WIDTH_FC-1:0]            data_a_reg;
  logic [DATA_WIDTH_FC-1:0]            data_b_reg;
  logic                                done_reg;
  logic                                fc_enable_reg;

  logic handshake;
  logic pair_write;
  logic last_pair;

  assign in_ready   = (state_reg == EVEN) || (state_reg == ODD);
  assign busy       = (state_reg != IDLE);
  assign handshake  = in_valid && in_ready;
  // A pair is committed when the odd word is accepted.
  assign pair_write = (state_reg == ODD) && in_valid;
  assign last_pair  = (bank_reg == BANK_W'(PI - 1)) &&
                      (local_reg == LOCAL_W'(PAIRS_PER_BANK - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      local_reg     <= '0;
      bank_reg      <= '0;
      hold_reg      <= '0;
      addr_a_reg    <= '0;
      addr_b_reg    <= '0;
      data_a_reg    <= '0;
      data_b_reg    <= '0;
      done_reg      <= 1'b0;
      fc_enable_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg     <= EVEN;
            local_reg     <= '0;
            bank_reg      <= '0;
            fc_enable_reg <= 1'b0;
          end
        end
        EVEN: begin
          if (handshake) begin
            hold_reg  <= in_data;
            state_reg <= ODD;
          end
        end
        ODD: begin
          if (handshake) begin
            addr_a_reg <= {local_reg, 1'b0};
            addr_b_reg <= {local_reg, 1'b1};
            data_a_reg <= hold_reg;
            data_b_reg <= in_data;
            if (last_pair) begin
              state_reg <= FIN;
            end else begin
              state_reg <= EVEN;
              if (local_reg == LOCAL_W'(PAIRS_PER_BANK - 1)) begin
                local_reg <= '0;
                bank_reg  <= bank_reg + 1'b1;
              end else begin
                local_reg <= local_reg + 1'b1;
              end
            end
          end
        end
        FIN: begin
          // The final pair write is on the RAM ports during this cycle, so
          // by the next edge the frame is complete.
          done_reg      <= 1'b1;
          fc_enable_reg <= 1'b1;
          state_reg     <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-bank write enables are registered individually so each bank sees a
  // clean single-cycle pulse with the matching address and data.
  generate
    for (genvar gi = 0; gi < PI; gi++) begin : g_bank_wren
      logic wren_a_bit_reg;
      logic wren_b_bit_reg;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          wren_a_bit_reg <= 1'b0;
          wren_b_bit_reg <= 1'b0;
        end else begin
          wren_a_bit_reg <= pair_write && (bank_reg == BANK_W'(gi));
          wren_b_bit_reg <= pair_write && (bank_reg == BANK_W'(gi));
        end
      end

      assign in_neuron_wren_a[gi] = wren_a_bit_reg;
      assign in_neuron_wren_b[gi] = wren_b_bit_reg;
    end
  endgenerate

  assign in_neuron_addr_a = addr_a_reg;
  assign in_neuron_addr_b = addr_b_reg;
  assign in_neuron_data_a = data_a_reg;
  assign in_neuron_data_b = data_b_reg;
  assign done             = done_reg;
  assign fc_enable        = fc_enable_reg;

endmodule
